// File: rtl/slt_seq_cmp_if.sv
// Handshake/operand bundle for the chunk-serial set-on-compare unit.
// Master drives requests and consumes results; slave is the compare unit.
interface slt_seq_cmp_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic             ovf;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, ovf
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, ovf
    );
endinterface

// File: rtl/slt_seq_cmp.sv
// Multi-cycle set-on-compare: A-B is formed CHUNK bits per cycle (LSB first),
// then SLT/SLTU/SEQ/SNE is resolved from N, V, C and the accumulated zero flag.
module slt_seq_cmp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    slt_seq_cmp_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic [WIDTH-1:0]  a_q, b_q, diff_q, diff_nxt;
    logic [1:0]        op_q;
    logic              carry_q, zero_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH:0]    result_q;
    logic              ovf_q;

    logic [CHUNK-1:0]  a_ch, b_ch;
    logic [CHUNK:0]    sum;
    logic              n_flag, v_flag, z_flag, cond, last;

    assign last = (cnt_q == LAST);

    // Chunk select by comparison against every index keeps the slice widths constant.
    always_comb begin
        a_ch     = '0;
        b_ch     = '0;
        diff_nxt = diff_q;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
        sum = {1'b0, a_ch} + {1'b0, ~b_ch} + {{CHUNK{1'b0}}, carry_q};
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) diff_nxt[i*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        end
        n_flag = diff_nxt[WIDTH-1];
        v_flag = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ n_flag);
        z_flag = zero_q & (sum[CHUNK-1:0] == '0);
        case (op_q)
            2'b00:   cond = n_flag ^ v_flag;
            2'b01:   cond = ~sum[CHUNK];
            2'b10:   cond = z_flag;
            default: cond = ~z_flag;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_nxt = CALC;
            CALC:    if (last) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            diff_q   <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.op;
                        diff_q  <= '0;
                        carry_q <= 1'b1;
                        zero_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    diff_q  <= diff_nxt;
                    carry_q <= sum[CHUNK];
                    zero_q  <= z_flag;
                    cnt_q   <= last ? '0 : cnt_q + CW'(1);
                    if (last) begin
                        result_q <= {{WIDTH{1'b0}}, cond};
                        ovf_q    <= v_flag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_slt_seq_cmp.sv
// Directed checks of slt_seq_cmp (WIDTH=32, CHUNK=8): flags, latency, backpressure,
// mid-compare reset, plus a short random sweep against a behavioural compare model.
module tb_slt_seq_cmp;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    slt_seq_cmp_if #(.WIDTH(32)) bus ();

    slt_seq_cmp #(.WIDTH(32), .CHUNK(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one op, scramble inputs during CALC, check latency/result/ovf, then drain.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic [1:0] top,
                          input logic exp_c, input logic exp_v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.a = ta; bus.b = tb_; bus.op = top; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) break;
        end
        chk({tag, ".latency"}, 64'(lat), 64'd4);
        chk({tag, ".result"}, 64'(bus.result), {31'd0, 32'd0, exp_c});
        chk({tag, ".ovf"}, 64'(bus.ovf), 64'(exp_v));
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, ".drain"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    endtask

    initial begin
        logic [31:0] ra, rb, rd;
        logic [1:0]  rop;
        logic        rc, rv;
        logic [32:0] held;

        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.op = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.result", 64'(bus.result), 64'd0);
        chk("rst.ovf", 64'(bus.ovf), 64'd0);

        run_op(32'h7FFFFFFF, 32'h80000000, 2'b00, 1'b0, 1'b1, "maxpos_slt");
        run_op(32'h7FFFFFFF, 32'h80000000, 2'b01, 1'b1, 1'b1, "maxpos_sltu");
        run_op(32'h80000000, 32'h00000001, 2'b00, 1'b1, 1'b1, "minneg_slt");
        run_op(32'h80000000, 32'h00000001, 2'b01, 1'b0, 1'b1, "minneg_sltu");
        run_op(32'd5, 32'd5, 2'b10, 1'b1, 1'b0, "eq_seq");
        run_op(32'd5, 32'd5, 2'b11, 1'b0, 1'b0, "eq_sne");
        run_op(32'd5, 32'd5, 2'b00, 1'b0, 1'b0, "eq_slt");
        run_op(32'd5, 32'd5, 2'b01, 1'b0, 1'b0, "eq_sltu");
        run_op(32'd3, 32'd0, 2'b01, 1'b0, 1'b0, "bzero_sltu");
        run_op(32'd0, 32'd1, 2'b01, 1'b1, 1'b0, "borrow_sltu");
        run_op(32'hFFFFFFFF, 32'd1, 2'b00, 1'b1, 1'b0, "neg1_slt");
        run_op(32'hFFFFFFFF, 32'd1, 2'b01, 1'b0, 1'b0, "neg1_sltu");
        run_op(32'h00000100, 32'd0, 2'b11, 1'b1, 1'b0, "chunk1_sne");
        run_op(32'h01000000, 32'd0, 2'b10, 1'b0, 1'b0, "chunk3_seq");

        // Backpressure: hold result for 10 cycles while a competing request is offered.
        @(negedge clk);
        bus.a = 32'd1; bus.b = 32'd2; bus.op = 2'b00; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 32'd9; bus.b = 32'd0; bus.op = 2'b10;
        repeat (4) @(posedge clk);
        #1;
        chk("bp.out_valid0", 64'(bus.out_valid), 64'd1);
        held = bus.result;
        chk("bp.result0", 64'(held), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold", {29'd0, bus.result, bus.out_valid, bus.in_ready}, {29'd0, 33'd1, 2'b10});
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp.release", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
        run_op(32'd9, 32'd0, 2'b10, 1'b0, 1'b0, "bp.next");

        // Reset in the second CALC cycle aborts the compare; prior result is cleared.
        run_op(32'd2, 32'd7, 2'b01, 1'b1, 1'b0, "pre_rst");
        @(negedge clk);
        bus.a = 32'd0; bus.b = 32'd0; bus.op = 2'b10; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("midrst.state", {61'd0, bus.out_valid, bus.in_ready, bus.ovf}, 64'b010);
        chk("midrst.result", 64'(bus.result), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("midrst.no_result", 64'(bus.out_valid), 64'd0);
        run_op(32'h80000000, 32'h7FFFFFFF, 2'b00, 1'b1, 1'b1, "post_rst");

        for (int i = 0; i < 200; i++) begin
            ra = $urandom; rb = $urandom; rop = 2'($urandom);
            if (i % 8 == 0) rb = ra;
            rd = ra - rb;
            rv = (ra[31] ^ rb[31]) & (ra[31] ^ rd[31]);
            case (rop)
                2'b00:   rc = ($signed(ra) < $signed(rb));
                2'b01:   rc = (ra < rb);
                2'b10:   rc = (ra == rb);
                default: rc = (ra != rb);
            endcase
            run_op(ra, rb, rop, rc, rv, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
